// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int DEPTH_DEFAULT = 256;

    typedef logic port_t;

    function automatic logic [1:0] port_mask(input port_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick with an exclusion mask
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      ptr,
    input  logic [1:0] excl,
    output logic [1:0] gnt
);

    logic [1:0] elig;

    assign elig = req & ~excl;
    assign gnt  = (&elig) ? port_mask(ptr) : elig;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin sequencer for a single-port data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t        state, nxt;
    port_t         ptr, lat_port;
    logic          lat_we, err_q, in_range, grant;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata, rdata_q;
    logic [1:0]    req_v, excl, gnt;

    // only IDLE and RESP may grant; the port being acked sits out its RESP cycle
    assign req_v    = (state == IDLE || state == RESP) ? {p1_req, p0_req} : 2'b00;
    assign excl     = (state == RESP) ? port_mask(lat_port) : 2'b00;
    assign grant    = |gnt;
    assign in_range = lat_addr < AW'(DEPTH);

    rr_arb2 u_arb (
        .req  (req_v),
        .ptr  (ptr),
        .excl (excl),
        .gnt  (gnt)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // latch the winner's command and hand priority to the other port
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= 1'b0;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            ptr       <= ~gnt[1];
            lat_port  <= gnt[1];
            lat_we    <= gnt[1] ? p1_we : p0_we;
            lat_addr  <= gnt[1] ? p1_addr : p0_addr;
            lat_wdata <= gnt[1] ? p1_wdata : p0_wdata;
        end
    end

    // capture the response at the end of the access cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            rdata_q <= (in_range && !lat_we) ? mem_rdata : '0;
            err_q   <= !in_range;
        end
    end

    // next state, memory command and port responses
    always_comb begin
        nxt       = state;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        case (state)
            IDLE:    nxt = grant ? ACCESS : IDLE;
            ACCESS: begin
                nxt       = RESP;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_read  = in_range && !lat_we && !reset;
                mem_write = in_range && lat_we && !reset;
            end
            RESP: begin
                nxt    = grant ? ACCESS : IDLE;
                p0_ack = !lat_port && !reset;
                p1_ack = lat_port && !reset;
            end
            default: nxt = IDLE;
        endcase
        p0_err   = p0_ack && err_q;
        p1_err   = p1_ack && err_q;
        p0_rdata = p0_ack ? rdata_q : '0;
        p1_rdata = p1_ack ? rdata_q : '0;
        busy     = state != IDLE;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a word-level memory reference model
module tb_dmem_arbiter;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          raise;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  ack, err;
    logic [31:0] rdata [2];
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    exp_t        q0[$], q1[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          last_wr_cyc = -1;
    logic [31:0] last_wr_addr, last_wr_data;

    assign mem_rdata = mem[mem_addr[7:0]];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (req[0]),
        .p0_we     (we[0]),
        .p0_addr   (addr[0]),
        .p0_wdata  (wdata[0]),
        .p0_ack    (ack[0]),
        .p0_err    (err[0]),
        .p0_rdata  (rdata[0]),
        .p1_req    (req[1]),
        .p1_we     (we[1]),
        .p1_addr   (addr[1]),
        .p1_wdata  (wdata[1]),
        .p1_ack    (ack[1]),
        .p1_err    (err[1]),
        .p1_rdata  (rdata[1]),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // raise one request, push its expected response, wait for ack, then drop req
    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int rc, output int ac);
        exp_t e;
        @(posedge clk);
        #1;
        req[p] = 1'b1;
        we[p] = w;
        addr[p] = a;
        wdata[p] = d;
        rc = cyc;
        e.err = a >= 32'd256;
        e.rdata = (e.err || w) ? 32'h0 : ref_mem[a[7:0]];
        e.raise = rc;
        if (!e.err && w) ref_mem[a[7:0]] = d;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
        ac = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack[p]) begin
                ac = cyc;
                break;
            end
        end
        if (ac < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL p%0d_ack_timeout: got no ack expected ack within 12 cycles", p);
            if (p == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        end
        @(posedge clk);
        #1;
        req[p] = 1'b0;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic rnd_port(input int p);
        int r, a;
        logic [31:0] ad;
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            ad = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100)
                                             : 32'(2 * $urandom_range(0, 127) + p);
            issue(p, 1'($urandom_range(0, 1)), ad, $urandom, r, a);
        end
    endtask

    initial begin
        int r0, a0, r1, a1, wc;
        exp_t e;
        logic pw;
        logic [31:0] pa, pd;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
            ref_mem[i] = mem[i];
        end
        addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
        // scoreboard monitor and environment memory
        fork
            forever begin
                @(negedge clk);
                pw = mem_write;
                pa = mem_addr;
                pd = mem_wdata;
                if (mem_write) begin
                    wr_cnt++;
                    last_wr_cyc = cyc;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                    chk("mem_write_in_range", 32'(mem_addr < 32'd256), 1);
                end
                if (!reset) begin
                    for (int p = 0; p < 2; p++) begin
                        if (ack[p]) begin
                            if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                                chk($sformatf("p%0d_unexpected_ack", p), 1, 0);
                            end else begin
                                e = (p == 0) ? q0.pop_front() : q1.pop_front();
                                chk($sformatf("p%0d_err", p), 32'(err[p]), 32'(e.err));
                                chk($sformatf("p%0d_rdata", p), rdata[p], e.rdata);
                                chk($sformatf("p%0d_latency_2to4", p),
                                    32'(cyc - e.raise >= 2 && cyc - e.raise <= 4), 1);
                            end
                        end
                    end
                end
                @(posedge clk);
                if (pw) mem[pa[7:0]] = pd;
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_p0_ack", 32'(ack[0]), 0);
        chk("rst_p1_ack", 32'(ack[1]), 0);
        chk("rst_p0_err", 32'(err[0]), 0);
        chk("rst_p0_rdata", rdata[0], 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(0, 1'b1, 32'd5, 32'hDEADBEEF, r0, a0);
        chk("wr5_ack_cycle", 32'(a0 - r0), 2);
        chk("wr5_commit_cycle", 32'(last_wr_cyc - r0), 1);
        chk("wr5_mem_addr", last_wr_addr, 32'd5);
        chk("wr5_mem_wdata", last_wr_data, 32'hDEADBEEF);
        issue(0, 1'b0, 32'd5, 32'h0, r0, a0);
        chk("rd5_ack_cycle", 32'(a0 - r0), 2);

        do_reset();
        fork
            issue(0, 1'b0, 32'd3, 32'h0, r0, a0);
            issue(1, 1'b0, 32'd4, 32'h0, r1, a1);
        join
        chk("pair1_p0_first", 32'(a0 - r0), 2);
        chk("pair1_p1_second", 32'(a1 - r1), 4);
        issue(0, 1'b0, 32'd10, 32'h0, r0, a0);
        fork
            issue(0, 1'b0, 32'd12, 32'h0, r0, a0);
            issue(1, 1'b0, 32'd13, 32'h0, r1, a1);
        join
        chk("pair2_p1_first", 32'(a1 - r1), 2);
        chk("pair2_p0_second", 32'(a0 - r0), 4);

        wc = wr_cnt;
        issue(1, 1'b1, 32'd256, 32'h1, r1, a1);
        issue(1, 1'b1, 32'h8000_0005, 32'h2, r1, a1);
        chk("oor_no_write", 32'(wr_cnt), 32'(wc));
        issue(1, 1'b1, 32'd255, 32'h1, r1, a1);
        chk("wr255_one_write", 32'(wr_cnt), 32'(wc + 1));
        chk("wr255_addr", last_wr_addr, 32'd255);
        issue(1, 1'b0, 32'd255, 32'h0, r1, a1);
        issue(1, 1'b0, 32'd256, 32'h0, r1, a1);

        fork
            repeat (6) issue(0, 1'b0, 32'd20, 32'h0, r0, a0);
            begin
                repeat (3) @(posedge clk);
                issue(1, 1'b0, 32'd21, 32'h0, r1, a1);
                chk("no_starve_p1", 32'(a1 - r1 <= 4), 1);
            end
        join

        fork
            rnd_port(0);
            rnd_port(1);
        join

        repeat (4) @(posedge clk);
        wc = wr_cnt;
        @(posedge clk);
        #1;
        req[0] = 1'b1;
        we[0] = 1'b1;
        addr[0] = 32'd7;
        wdata[0] = 32'h1234_5678;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_access_mem_write", 32'(mem_write), 0);
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        chk("rst_access_busy", 32'(busy), 0);
        chk("rst_access_no_ack", 32'(ack[0]), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_access_no_write", 32'(wr_cnt), 32'(wc));
        chk("rst_access_addr7", mem[7], ref_mem[7]);

        repeat (6) @(posedge clk);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
